// File: rtl/rename_alloc_ctrl.sv
// Rename free-tag allocator: circular pool with speculative/committed heads.
// Two-lane allocate, two-port release, flush rolls head back to commit point.
module rename_alloc_ctrl #(
    parameter int PWIDTH = 6,
    parameter int NFREE  = 32,
    parameter int STNUM  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [1:0]                 i_req,
    input  logic [1:0]                 i_rel_v,
    input  logic [PWIDTH-1:0]          i_rel_tag0,
    input  logic [PWIDTH-1:0]          i_rel_tag1,
    input  logic [1:0]                 i_cmt_n,
    input  logic                       i_flush,
    output logic [PWIDTH-1:0]          o_tag0,
    output logic [PWIDTH-1:0]          o_tag1,
    output logic [1:0]                 o_gnt,
    output logic                       o_stall,
    output logic [$clog2(NFREE):0]     o_count,
    output logic                       o_err
);

    localparam int AW = $clog2(NFREE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(NFREE);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [PWIDTH-1:0] pool_q [NFREE];

    ptr_t head_q, head_d;
    ptr_t chead_q, chead_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;
    cnt_t ccount_q, ccount_d;
    logic err_q, err_d;

    ptr_t head_p1, tail_p1, fl_diff;
    cnt_t need, granted, room, nrel, acc, cmt, fl_cnt;
    logic gnt_ok, drop, cmt3, wr0, wr1;
    logic [PWIDTH-1:0] wdata0;

    always_comb begin
        head_p1 = head_q + ptr_t'(1);
        tail_p1 = tail_q + ptr_t'(1);

        need    = cnt_t'(i_req[0]) + cnt_t'(i_req[1]);
        gnt_ok  = (need <= count_q) & ~i_flush;
        o_stall = (need > count_q) & ~i_flush;
        o_gnt   = i_req & {2{gnt_ok}};
        granted = gnt_ok ? need : '0;

        o_tag0 = pool_q[head_q];
        o_tag1 = i_req[0] ? pool_q[head_p1] : pool_q[head_q];

        // releases beyond the free space are dropped, port1 first
        room   = FULL - count_q;
        nrel   = cnt_t'(i_rel_v[0]) + cnt_t'(i_rel_v[1]);
        drop   = nrel > room;
        acc    = drop ? room : nrel;
        wr0    = acc != '0;
        wr1    = acc == cnt_t'(2);
        wdata0 = i_rel_v[0] ? i_rel_tag0 : i_rel_tag1;
        tail_d = tail_q + ptr_t'(acc);

        cmt3     = &i_cmt_n;
        cmt      = cmt3 ? cnt_t'(2) : cnt_t'(i_cmt_n);
        chead_d  = chead_q + ptr_t'(cmt);
        ccount_d = ccount_q + acc - cmt;

        // pointer tie on flush: committed free count tells empty from full
        fl_diff = chead_d - tail_d;
        if (fl_diff == '0) begin
            fl_cnt = (ccount_d == '0) ? '0 : FULL;
        end else begin
            fl_cnt = FULL - cnt_t'(fl_diff);
        end

        head_d  = i_flush ? chead_d : head_q + ptr_t'(granted);
        count_d = i_flush ? fl_cnt : count_q + acc - granted;
        err_d   = err_q | drop | cmt3;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NFREE; i++) begin
                pool_q[i] <= PWIDTH'(STNUM + i);
            end
        end else begin
            if (wr0) pool_q[tail_q]  <= wdata0;
            if (wr1) pool_q[tail_p1] <= i_rel_tag1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q   <= '0;
            chead_q  <= '0;
            tail_q   <= '0;
            count_q  <= FULL;
            ccount_q <= FULL;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            chead_q  <= chead_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ccount_q <= ccount_d;
            err_q    <= err_d;
        end
    end

    assign o_count = count_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl with hand-computed expectations.
module tb_rename_alloc_ctrl;

    localparam int PW = 6;
    localparam int NF = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    rel_v;
    logic [PW-1:0] rel_tag0;
    logic [PW-1:0] rel_tag1;
    logic [1:0]    cmt_n;
    logic          flush;
    logic [PW-1:0] tag0;
    logic [PW-1:0] tag1;
    logic [1:0]    gnt;
    logic          stall;
    logic [5:0]    count;
    logic          err;

    int n_chk;
    int n_fail;
    int exp_q[$];

    rename_alloc_ctrl #(.PWIDTH(PW), .NFREE(NF), .STNUM(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_rel_v    (rel_v),
        .i_rel_tag0 (rel_tag0),
        .i_rel_tag1 (rel_tag1),
        .i_cmt_n    (cmt_n),
        .i_flush    (flush),
        .o_tag0     (tag0),
        .o_tag1     (tag1),
        .o_gnt      (gnt),
        .o_stall    (stall),
        .o_count    (count),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 2'b00; rel_v = 2'b00; rel_tag0 = '0; rel_tag1 = '0;
        cmt_n = 2'b00; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32);
        check("rst_tag0", 32'(tag0), 32);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_err", 32'(err), 0);

        req = 2'b11; #1;
        check("a11_tag0", 32'(tag0), 32);
        check("a11_tag1", 32'(tag1), 33);
        check("a11_gnt", 32'(gnt), 3);
        step();
        check("a11_count", 32'(count), 30);

        req = 2'b10; #1;
        check("a10_tag1", 32'(tag1), 34);
        check("a10_gnt", 32'(gnt), 2);
        step();
        check("a10_count", 32'(count), 29);

        repeat (14) begin req = 2'b11; step(); end
        check("drain_count", 32'(count), 1);
        req = 2'b11; #1;
        check("short_stall", 32'(stall), 1);
        check("short_gnt", 32'(gnt), 0);
        step();
        check("short_count", 32'(count), 1);
        req = 2'b01; #1;
        check("last_gnt", 32'(gnt), 1);
        check("last_tag0", 32'(tag0), 63);
        step();
        check("empty_count", 32'(count), 0);
        req = 2'b00; #1;
        check("empty_nostall", 32'(stall), 0);

        do_reset();
        req = 2'b11; step(); step();
        req = 2'b00; cmt_n = 2'd2; step();
        cmt_n = 2'd0; flush = 1'b1; req = 2'b11; #1;
        check("flush_gnt", 32'(gnt), 0);
        check("flush_stall", 32'(stall), 0);
        step();
        idle(); #1;
        check("flush_tag0", 32'(tag0), 34);
        check("flush_count", 32'(count), 30);

        do_reset();
        req = 2'b11; step();
        req = 2'b00; cmt_n = 2'd2; step();
        cmt_n = 2'd0; flush = 1'b1; rel_v = 2'b01; rel_tag0 = 6'd9;
        step();
        idle(); #1;
        check("flrel_count", 32'(count), 31);
        check("flrel_tag0", 32'(tag0), 34);

        do_reset();
        rel_v = 2'b11; rel_tag0 = 6'd5; rel_tag1 = 6'd6;
        step();
        idle(); #1;
        check("ovf_count", 32'(count), 32);
        check("ovf_err", 32'(err), 1);
        check("ovf_tag0", 32'(tag0), 32);
        step();
        check("ovf_err_hold", 32'(err), 1);
        do_reset();
        check("err_clear", 32'(err), 0);

        req = 2'b01; step();
        req = 2'b00; rel_v = 2'b11; rel_tag0 = 6'd10; rel_tag1 = 6'd11;
        step();
        idle(); #1;
        check("part_count", 32'(count), 32);
        check("part_err", 32'(err), 1);
        repeat (15) begin req = 2'b11; step(); end
        req = 2'b01; step();
        req = 2'b00; #1;
        check("part_cnt1", 32'(count), 1);
        check("part_tag0", 32'(tag0), 10);

        do_reset();
        cmt_n = 2'd3; step();
        idle(); #1;
        check("cmt3_err", 32'(err), 1);

        do_reset();
        repeat (15) begin req = 2'b11; step(); end
        req = 2'b01; step();
        req = 2'b11; rel_v = 2'b01; rel_tag0 = 6'd20; #1;
        check("nb_stall", 32'(stall), 1);
        check("nb_tag0", 32'(tag0), 63);
        step();
        rel_v = 2'b00; #1;
        check("nb_count", 32'(count), 2);
        check("nb_gnt", 32'(gnt), 3);
        check("nb_tag1", 32'(tag1), 20);

        do_reset();
        exp_q.delete();
        for (int i = 0; i < NF; i++) exp_q.push_back(32 + i);
        req = 2'b01; step();
        void'(exp_q.pop_front());
        for (int k = 0; k < 40; k++) begin
            req = 2'b01; rel_v = 2'b01; rel_tag0 = PW'(k); #1;
            check($sformatf("wrap_tag%0d", k), 32'(tag0), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(k);
            step();
        end
        check("wrap_count", 32'(count), 31);
        rst = 1'b1; step();
        rst = 1'b0;
        idle(); #1;
        check("mid_rst_count", 32'(count), 32);
        check("mid_rst_tag0", 32'(tag0), 32);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_gnt", 32'(gnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_alloc_ctrl.md
RENAME_ALLOC_CTRL -- requirements
Module: rename_alloc_ctrl

Interface
REQ-001 Parameters, one per line: PWIDTH, 6, physical tag width; NFREE, 32, free-pool capacity (power of two); STNUM, 32, first tag loaded at reset.
REQ-002 Reset is synchronous and active-high, named i_rst; single clock named i_clk; all state updates on posedge i_clk only.
REQ-003 Ports, one per line: name, direction, width, meaning.
- i_clk  in  1  clock
- i_rst  in  1  sync reset, active-high
- i_req  in  2  per-lane allocation request (bit0 = lane0, older)
- i_rel_v  in  2  per-port release valid from commit
- i_rel_tag0  in  PWIDTH  tag freed on port 0
- i_rel_tag1  in  PWIDTH  tag freed on port 1
- i_cmt_n  in  2  number of committing instructions that allocated (0..2)
- i_flush  in  1  rename rollback to the committed state
- o_tag0  out  PWIDTH  tag for lane0
- o_tag1  out  PWIDTH  tag for lane1
- o_gnt  out  2  per-lane grant
- o_stall  out  1  insufficient free tags; decode holds
- o_count  out  $clog2(NFREE)+1  free tags available
- o_err  out  1  sticky release-overflow error

Function
REQ-004 Circular pool of NFREE entries; pointers head (speculative), chead (committed), tail; all wrap NFREE-1 -> 0.
REQ-005 Occupancy tracked by counter o_count; head==tail is disambiguated by o_count (0 = empty, NFREE = full).
REQ-006 need = popcount(i_req); o_stall = (need > o_count) & ~i_flush, combinational.
REQ-007 o_gnt = i_req & {2{~o_stall & ~i_flush}}; grants are all-or-nothing, no partial grant.
REQ-008 o_tag0 = pool[head]; o_tag1 = pool[head+1] if i_req[0], else pool[head]; both combinational.
REQ-009 On a grant, head advances by need at the next edge.
REQ-010 Release compaction: the first valid port writes pool[tail], the second valid port writes pool[tail+1]; tail advances by popcount(i_rel_v).
REQ-011 A released tag becomes allocatable the next cycle; no same-cycle bypass to o_tag*.
REQ-012 Next count = o_count + released - granted, all in one cycle.
REQ-013 Release when o_count + released > NFREE: the excess port(s) are dropped (port1 dropped first), tail and count do not overflow, and o_err sets; o_err holds until reset.
REQ-014 chead advances by i_cmt_n each cycle; i_cmt_n=3 is illegal and treated as 2, with o_err set.
REQ-015 i_flush: head <= chead + i_cmt_n (same-cycle commit applied); o_count <= NFREE - ((chead_next - tail) mod NFREE), with the full case resolved by released tags; no grants that cycle.
REQ-016 Flush with simultaneous releases: the releases are accepted and included in the recomputed count.
REQ-017 Storage writes need no reset other than the REQ-018 initialisation.

Reset
REQ-018 On i_rst: pool[i] = STNUM+i for all i; head = chead = tail = 0; o_count = NFREE; o_err = 0.
REQ-019 Outputs during and right after reset: o_gnt = 00 and o_stall = 0 when i_req = 00; o_tag0 = STNUM.
REQ-020 Reset overrides flush, allocation and release in the same cycle.

Verification
REQ-021 After reset, i_req=11 -> o_tag0=32, o_tag1=33, o_gnt=11; next cycle o_count=30.
REQ-022 Continuing, i_req=10 -> o_tag1=34, o_gnt=10; next cycle o_count=29.
REQ-023 Drain to o_count=1, i_req=11 -> o_stall=1, o_gnt=00, count stays 1; i_req=01 -> o_gnt=01, o_tag0 = next head tag.
REQ-024 From reset, allocate 4 (32..35), i_cmt_n=2 for one cycle, then i_flush -> next cycle o_tag0=34, o_count=30.
REQ-025 At o_count=32, i_rel_v=11 -> both releases dropped, o_err=1 and holds; count stays 32.
REQ-026 Wrap test: 40 cycles of alloc-1 plus release-1 with tags 0..39 -> the tag sequence wraps index 31 -> 0 without loss; i_rst mid-sequence restores the REQ-018 state the next cycle.
